// File: rtl/mult_seq_pkg.sv
// Shared types and elaboration helpers for the sequential radix multiplier.
package mult_seq_pkg;

    // Controller states; 2-bit encoding keeps the state register minimal.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Bits-per-cycle values the partial-product generator is built for.
    function automatic bit legal_bpc(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4);
    endfunction

endpackage

// File: rtl/mult_seq_radix_if.sv
// Request/result handshake bundle between a client and the sequential multiplier.
interface mult_seq_radix_if #(
    parameter int N = 16
);
    logic           req_valid;
    logic           req_ready;
    logic           sgn;
    logic [N-1:0]   ain;
    logic [N-1:0]   bin;
    logic           abort;
    logic           busy;
    logic [2*N-1:0] yout;
    logic           yout_valid;
    logic           yout_ready;

    // Client side: issues operands, consumes results.
    modport master (
        output req_valid, sgn, ain, bin, abort, yout_ready,
        input  req_ready, busy, yout, yout_valid
    );

    // Multiplier side.
    modport slave (
        input  req_valid, sgn, ain, bin, abort, yout_ready,
        output req_ready, busy, yout, yout_valid
    );
endinterface

// File: rtl/mult_pp_digit.sv
// Combinational partial product: W-bit multiplicand times a BPC-bit multiplier digit.
module mult_pp_digit #(
    parameter int W   = 32,
    parameter int BPC = 1
) (
    input  logic [W-1:0]   mag_a_i,
    input  logic [BPC-1:0] digit_i,
    output logic [W-1:0]   pp_o
);

    generate
        if (BPC == 1) begin : g_and_row
            // Single-bit digit: the product is the multiplicand gated by that bit.
            assign pp_o = mag_a_i & {W{digit_i[0]}};
        end else begin : g_shift_add
            logic [W-1:0] term_w [BPC];

            for (genvar gi = 0; gi < BPC; gi++) begin : g_term
                assign term_w[gi] = digit_i[gi] ? (mag_a_i << gi) : '0;
            end

            // Sum the shifted multiplicand copies selected by the digit bits.
            always_comb begin
                pp_o = '0;
                for (int i = 0; i < BPC; i++) begin
                    pp_o = pp_o + term_w[i];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mult_seq_radix.sv
// Sequential N x N -> 2N multiplier retiring BPC multiplier bits per cycle, with
// signed/unsigned mode, early exit on exhausted multiplier and synchronous abort.
import mult_seq_pkg::*;

module mult_seq_radix #(
    parameter int N   = 16,
    parameter int BPC = 1
) (
    input  logic            clk,
    input  logic            resetb,
    mult_seq_radix_if.slave bus
);

    generate
        if (!legal_bpc(BPC) || ((N % BPC) != 0)) begin : g_bad_cfg
            $error("mult_seq_radix: BPC must be 1, 2 or 4 and divide N");
        end
    endgenerate

    state_e         state_q;
    logic [2*N-1:0] mag_a_q;
    logic [N-1:0]   mag_b_q;
    logic [2*N-1:0] acc_q;
    logic           neg_q;
    logic [2*N-1:0] yout_q;
    logic           yout_valid_q;

    logic [N-1:0]   abs_a_d;
    logic [N-1:0]   abs_b_d;
    logic           neg_d;
    logic [2*N-1:0] pp_d;
    logic [2*N-1:0] acc_d;
    logic [2*N-1:0] yout_d;

    // Operand magnitudes; -2^(N-1) maps onto 2^(N-1), which still fits N unsigned bits.
    assign abs_a_d = (bus.sgn && bus.ain[N-1]) ? (~bus.ain + 1'b1) : bus.ain;
    assign abs_b_d = (bus.sgn && bus.bin[N-1]) ? (~bus.bin + 1'b1) : bus.bin;
    assign neg_d   = bus.sgn & (bus.ain[N-1] ^ bus.bin[N-1]);

    mult_pp_digit #(
        .W   (2*N),
        .BPC (BPC)
    ) u_pp (
        .mag_a_i (mag_a_q),
        .digit_i (mag_b_q[BPC-1:0]),
        .pp_o    (pp_d)
    );

    assign acc_d  = acc_q + pp_d;
    // Negating a zero accumulator yields zero, so no "negative zero" can appear.
    assign yout_d = neg_q ? (~acc_q + 1'b1) : acc_q;

    // Controller and datapath registers; outputs come straight from registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            mag_a_q      <= '0;
            mag_b_q      <= '0;
            acc_q        <= '0;
            neg_q        <= 1'b0;
            yout_q       <= '0;
            yout_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Abort is not considered here: a request alongside it is accepted.
                    if (bus.req_valid) begin
                        state_q <= RUN;
                        mag_a_q <= {{N{1'b0}}, abs_a_d};
                        mag_b_q <= abs_b_d;
                        neg_q   <= neg_d;
                        acc_q   <= '0;
                        yout_q  <= '0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (mag_b_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        acc_q   <= acc_d;
                        mag_a_q <= mag_a_q << BPC;
                        mag_b_q <= mag_b_q >> BPC;
                    end
                end
                FIX: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else begin
                        yout_q       <= yout_d;
                        yout_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    // Result stays presented until taken; yout keeps its value afterwards.
                    if (bus.yout_ready) begin
                        yout_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.yout       = yout_q;
    assign bus.yout_valid = yout_valid_q;

endmodule

// File: tb/tb_mult_seq_radix.sv
// Scoreboard bench: dut0 runs BPC=1, dut1 runs BPC=4; a negedge monitor checks results.
module tb_mult_seq_radix;

    localparam int N = 16;

    typedef struct packed {
        logic [2*N-1:0] y;
        int             lat;
        int             acc_edge;
    } exp_t;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    mult_seq_radix_if #(.N(N)) bus0 ();
    mult_seq_radix_if #(.N(N)) bus1 ();

    mult_seq_radix #(.N(N), .BPC(1)) u_dut0 (.clk(clk), .resetb(resetb), .bus(bus0));
    mult_seq_radix #(.N(N), .BPC(4)) u_dut1 (.clk(clk), .resetb(resetb), .bus(bus1));

    logic           rv [2];
    logic           sg [2];
    logic           ab [2];
    logic           yr [2];
    logic [N-1:0]   aa [2];
    logic [N-1:0]   bb [2];
    logic           rr [2];
    logic           bz [2];
    logic           yv [2];
    logic [2*N-1:0] yy [2];

    assign bus0.req_valid = rv[0];  assign bus1.req_valid = rv[1];
    assign bus0.sgn = sg[0];        assign bus1.sgn = sg[1];
    assign bus0.abort = ab[0];      assign bus1.abort = ab[1];
    assign bus0.yout_ready = yr[0]; assign bus1.yout_ready = yr[1];
    assign bus0.ain = aa[0];        assign bus1.ain = aa[1];
    assign bus0.bin = bb[0];        assign bus1.bin = bb[1];
    assign rr[0] = bus0.req_ready;  assign rr[1] = bus1.req_ready;
    assign bz[0] = bus0.busy;       assign bz[1] = bus1.busy;
    assign yv[0] = bus0.yout_valid; assign yv[1] = bus1.yout_valid;
    assign yy[0] = bus0.yout;       assign yy[1] = bus1.yout;

    exp_t q0[$];
    exp_t q1[$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    function automatic void qpush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int d);
        exp_t e;
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        return e;
    endfunction

    // Reference product for random vectors.
    function automatic logic [2*N-1:0] ref_mul(input bit s, input logic [N-1:0] a, input logic [N-1:0] b);
        longint p;
        logic [63:0] pv;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({48'd0, a}) * longint'({48'd0, b});
        pv = p;
        return pv[2*N-1:0];
    endfunction

    // Expected edges from accept to yout_valid for a given multiplier.
    function automatic int lat_of(input bit s, input logic [N-1:0] b, input int bpc);
        logic [N-1:0] mb;
        int nb;
        mb = (s && b[N-1]) ? -b : b;
        nb = 0;
        for (int i = 0; i < N; i++) if (mb[i]) nb = i + 1;
        return (nb + bpc - 1) / bpc + 2;
    endfunction

    // Monitor: pop and compare on each rising yout_valid, then check yout holds.
    bit             seen [2];
    logic [2*N-1:0] held [2];
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!resetb || !yv[d]) begin
                seen[d] = 1'b0;
            end else if (!seen[d]) begin
                seen[d] = 1'b1;
                held[d] = yy[d];
                if (qsize(d) == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result dut%0d: yout=%0h, required no result", d, yy[d]);
                end else begin
                    e = qpop(d);
                    chk($sformatf("yout_dut%0d", d), {32'd0, yy[d]}, {32'd0, e.y});
                    if (e.lat >= 0) chk($sformatf("latency_dut%0d", d), 64'(cyc - e.acc_edge), 64'(e.lat));
                end
            end else begin
                chk($sformatf("yout_hold_dut%0d", d), {32'd0, yy[d]}, {32'd0, held[d]});
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, optionally queue the expected result.
    task automatic issue(input int d, input bit s, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit push, input logic [2*N-1:0] y, input int lat);
        exp_t e;
        int t;
        sg[d] = s; aa[d] = a; bb[d] = b; rv[d] = 1'b1;
        t = 0;
        while (!rr[d] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rr[d]) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: req_ready=0, required 1", d);
        end else if (push) begin
            e.y = y; e.lat = lat; e.acc_edge = cyc + 1;
            qpush(d, e);
        end
        @(posedge clk);
        #1;
        rv[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int t;
        t = 0;
        while ((qsize(d) != 0 || !rr[d]) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout dut%0d: pending=%0d, required 0", d, qsize(d));
        end
    endtask

    task automatic wait_valid(input int d);
        int t;
        t = 0;
        while (!yv[d] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_valid", {63'd0, yv[d]}, 64'd1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rv[d] = 0; sg[d] = 0; ab[d] = 0; yr[d] = 1; aa[d] = '0; bb[d] = '0;
        end
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'd0, rr[0]}, 64'd1);
        chk("rst_busy", {63'd0, bz[0]}, 64'd0);
        chk("rst_yout_valid", {63'd0, yv[0]}, 64'd0);
        chk("rst_yout", {32'd0, yy[0]}, 64'd0);
        resetb = 1'b1;
        @(negedge clk);

        // Directed unsigned/signed on BPC=1
        issue(0, 0, 16'd3, 16'd5, 1, 32'h0000000F, 5);          wait_done(0);
        issue(0, 1, 16'h8000, 16'h8000, 1, 32'h40000000, 18);   wait_done(0);
        issue(0, 1, 16'hFFFF, 16'd7, 1, 32'hFFFFFFF9, 5);       wait_done(0);
        issue(0, 1, 16'hFFFF, 16'd0, 1, 32'h00000000, 2);       wait_done(0);
        issue(0, 1, 16'd0, 16'hFFFF, 1, 32'h00000000, 3);       wait_done(0);

        // Directed on BPC=4
        issue(1, 0, 16'hFFFF, 16'hFFFF, 1, 32'hFFFE0001, 6);    wait_done(1);
        issue(1, 0, 16'h1234, 16'h0000, 1, 32'h00000000, 2);    wait_done(1);
        issue(1, 1, 16'hFFFD, 16'd5, 1, 32'hFFFFFFF1, 3);       wait_done(1);
        issue(1, 1, 16'h8000, 16'h8000, 1, 32'h40000000, 6);    wait_done(1);

        // Backpressure: result held, requests ignored, then consume + accept
        yr[0] = 1'b0;
        issue(0, 0, 16'd3, 16'd5, 1, 32'h0000000F, 5);
        wait_valid(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rv[0] = 1'b1; aa[0] = 16'hAAAA; bb[0] = 16'h5555;
            chk("bp_valid", {63'd0, yv[0]}, 64'd1);
            chk("bp_ready", {63'd0, rr[0]}, 64'd0);
        end
        yr[0] = 1'b1;
        issue(0, 0, 16'd7, 16'd9, 1, 32'd63, 6);
        wait_done(0);

        // Abort on the 3rd RUN edge
        issue(0, 0, 16'h00FF, 16'h0F0F, 0, '0, -1);
        repeat (3) @(negedge clk);
        ab[0] = 1'b1;
        @(posedge clk);
        #1;
        ab[0] = 1'b0;
        chk("abort_busy", {63'd0, bz[0]}, 64'd0);
        chk("abort_ready", {63'd0, rr[0]}, 64'd1);
        chk("abort_yout", {32'd0, yy[0]}, 64'd0);
        chk("abort_valid", {63'd0, yv[0]}, 64'd0);
        issue(0, 0, 16'd2, 16'd3, 1, 32'd6, 4);
        wait_done(0);

        // Abort together with a request in IDLE: request wins
        ab[0] = 1'b1;
        issue(0, 0, 16'd4, 16'd4, 1, 32'd16, 5);
        ab[0] = 1'b0;
        wait_done(0);

        // Abort in DONE is ignored
        yr[0] = 1'b0;
        issue(0, 1, 16'hFFFE, 16'd2, 1, 32'hFFFFFFFC, 4);
        wait_valid(0);
        ab[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_done_valid", {63'd0, yv[0]}, 64'd1);
        chk("abort_done_yout", {32'd0, yy[0]}, 64'h00000000FFFFFFFC);
        ab[0] = 1'b0;
        yr[0] = 1'b1;
        wait_done(0);

        // Reset mid-RUN
        issue(0, 0, 16'h1234, 16'h4321, 0, '0, -1);
        repeat (2) @(negedge clk);
        resetb = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, rr[0]}, 64'd1);
        chk("midrst_busy", {63'd0, bz[0]}, 64'd0);
        chk("midrst_valid", {63'd0, yv[0]}, 64'd0);
        chk("midrst_yout", {32'd0, yy[0]}, 64'd0);
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);

        // Random signed and unsigned pairs on both instances
        for (int i = 0; i < 1000; i++) begin
            bit s;
            logic [N-1:0] a;
            logic [N-1:0] b;
            int d;
            s = 1'($urandom_range(0, 1));
            a = N'($urandom);
            b = N'($urandom);
            if (i % 8 == 1) b = N'($urandom_range(0, 15));
            d = (i % 4 == 0) ? 1 : 0;
            issue(d, s, a, b, 1, ref_mul(s, a, b), lat_of(s, b, (d == 1) ? 4 : 1));
            wait_done(d);
        end

        repeat (3) @(negedge clk);
        chk("queue0_drained", 64'(q0.size()), 64'd0);
        chk("queue1_drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
